uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the team's 8N1 UART link.
- Frame format: start bit 0, 8 data bits LSB first, one stop bit 1; line idles high.
- Samples serial_in on an oversampling enable tick, rebuilds the byte and presents it on a parallel bus with a valid/ack handshake.
- Reports framing and overrun errors.

Parameters:
- OVERSAMPLE, 8, sample_tick pulses per bit period; power of two, at least 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous reset, active-low.
- serial_in  input  1  UART line, idle high.
- sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
- read_ack  input  1  one-clk pulse: consumer has taken data_out.
- err_clr  input  1  one-clk pulse: clears frame_err and overrun_err.
- data_out  output  8  last good received byte.
- data_valid  output  1  data_out holds an unread byte.
- rx_busy  output  1  high in any state other than IDLE.
- frame_err  output  1  sticky: stop bit sampled 0.
- overrun_err  output  1  sticky: frame completed while data_valid was still 1.

Behaviour:
- Reset values: data_out=0, data_valid=0, rx_busy=0, frame_err=0, overrun_err=0, state=IDLE, counters=0, shift register=0.
- rstn low mid-frame aborts the frame immediately; no partial data is ever loaded.
- Counters:
  - sample_cnt is clog2(OVERSAMPLE) bits wide, wraps naturally.
  - bit_cnt is clog2(DATA_BITS+1) bits wide.
  - Both advance only on sample_tick cycles.
- States:
  - IDLE: on sample_tick with serial_in=0, go to START with sample_cnt=0.
  - START: on each tick, increment sample_cnt. At sample_cnt=OVERSAMPLE/2-1 (mid start bit), re-check serial_in:
    - serial_in=0: go to RECV, clear sample_cnt and bit_cnt.
    - serial_in=1: false start (glitch); go back to IDLE with no flags set.
  - RECV: on each tick, increment sample_cnt. When sample_cnt=OVERSAMPLE-1 (bit centre):
    - shift serial_in into the MSB of the shift register, shifting right;
    - increment bit_cnt;
    - clear sample_cnt.
    - After DATA_BITS samples, go to STOP.
  - STOP: at sample_cnt=OVERSAMPLE-1, sample the stop bit and go to IDLE in the same cycle. Outcomes:
    - Stop bit 1 and data_valid=0: data_out <= shift register, data_valid <= 1 on the next clk edge.
    - Stop bit 1 and data_valid=1 with no read_ack that cycle: overrun_err <= 1; data_out keeps the old byte.
    - Stop bit 0: frame_err <= 1; data_out and data_valid are unchanged.
- Handshake:
  - data_valid stays high until read_ack; it goes low on the clk after read_ack.
  - read_ack while data_valid=0 is ignored.
  - read_ack in the same cycle as a good load: the load wins, data_valid stays 1, and no overrun is flagged.
- Error flags:
  - Cleared only by err_clr or reset.
  - err_clr in the same cycle as a new error: the set wins.
- Cycles with sample_tick=0 never change state or counters.
- Latency: data_valid rises 1 clk after the stop-bit centre tick.
- Back-to-back frames: a new start bit is accepted on the first tick after returning to IDLE.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: serial_in passes through a two-flop synchronizer (reset value 1) before all use; adds 2 clk of latency.
- Undefined: serial_in is used directly; the source must already be in the clk domain.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef: IDLE, START, RECV, STOP as 2-bit localparams;
  - DATA_BITS default;
  - line idle-level constant.
  - The transmitter should take its constants from the same package.
- One sub-module is natural: uart_sync_2ff (generic 1-bit double-flop synchronizer, reset to 1), instantiated only under UART_RX_SYNC_EN.

Test Plan:
- OVERSAMPLE=8, sample_tick every 4 clk, frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> data_out=0xA5 and data_valid=1 one clk after the stop-bit centre tick; errors stay 0.
- serial_in low for 2 ticks then high -> START is entered then abandoned at the mid check; back in IDLE; data_valid=0; no flags.
- Frame 0x3C with stop bit 0 -> frame_err=1, data_valid=0, data_out unchanged; err_clr pulse -> frame_err=0.
- Frames 0x11 then 0x22 with no read_ack -> data_out=0x11, data_valid=1, overrun_err=1.
- Same sequence with read_ack pulsed in the cycle 0x22 loads -> data_out=0x22, data_valid=1, overrun_err=0.
- rstn asserted mid-RECV after 4 bits -> all outputs at reset values at once; the next full frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Constants shared by the UART receiver and transmitter: the
//             receiver state encoding, the default frame width and the line
//             idle level.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver state encoding, explicit 2-bit width.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t RECV  = 2'd2;
  localparam state_t STOP  = 2'd3;

  // Default number of data bits per frame.
  localparam int c_DATA_BITS = 8;

  // Level of the serial line between frames (also the stop-bit level).
  localparam logic c_LINE_IDLE = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_2ff
//  Purpose  : Generic 1-bit double-flop synchronizer. Both flops reset to 1
//             so an idle-high serial line does not show a false start bit
//             while reset is released.
//  Ports    : clk  - destination clock
//             rstn - asynchronous reset, active-low
//             d    - asynchronous input
//             q    - synchronized output (2 clk latency)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : uart_sync_2ff
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 UART receiver. Oversamples serial_in on sample_tick,
//             rebuilds each byte LSB first and presents it on data_out with
//             a data_valid / read_ack handshake. Reports sticky framing and
//             overrun errors.
//  Macro    : UART_RX_SYNC_EN - when defined, serial_in passes through a
//             two-flop synchronizer (uart_sync_2ff) before any use, adding
//             2 clk of latency. When undefined serial_in must already be in
//             the clk domain.
//  Ports    : clk         - system clock
//             rstn        - asynchronous reset, active-low
//             serial_in   - UART line, idle high
//             sample_tick - one-clk enable at OVERSAMPLE x baud rate
//             read_ack    - one-clk pulse, consumer has taken data_out
//             err_clr     - one-clk pulse, clears frame_err / overrun_err
//             data_out    - last good received byte
//             data_valid  - data_out holds an unread byte
//             rx_busy     - receiver is not in IDLE
//             frame_err   - sticky, stop bit sampled 0
//             overrun_err - sticky, frame completed while data_valid was 1
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = c_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 sample_tick,
  input  logic                 read_ack,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int c_SW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS + 1);

  localparam logic [c_SW-1:0] c_SAMPLE_MID  = c_SW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_SW-1:0] c_SAMPLE_LAST = c_SW'(OVERSAMPLE - 1);
  localparam logic [c_SW-1:0] c_SAMPLE_ONE  = c_SW'(1);
  localparam logic [c_BW-1:0] c_BIT_LAST    = c_BW'(DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_BIT_ONE     = c_BW'(1);

  // --------------------------------------------------------------------------
  // Line input
  // --------------------------------------------------------------------------
  logic w_rx;

`ifdef UART_RX_SYNC_EN
  uart_sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (serial_in),
    .q    (w_rx)
  );
`else
  assign w_rx = serial_in;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [c_SW-1:0]       r_sample_cnt;
  logic [c_BW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_frame_err;
  logic                  r_overrun_err;

  // Stop-bit centre tick and its three possible outcomes. A read_ack in the
  // same cycle as a good stop bit frees the buffer, so the new byte loads
  // instead of being counted as an overrun.
  logic w_stop_tick;
  logic w_good_stop;
  logic w_load;
  logic w_overrun_set;
  logic w_frame_set;

  assign w_stop_tick   = sample_tick && (r_state == STOP) && (r_sample_cnt == c_SAMPLE_LAST);
  assign w_good_stop   = w_stop_tick && (w_rx == c_LINE_IDLE);
  assign w_load        = w_good_stop && (!r_valid || read_ack);
  assign w_overrun_set = w_good_stop && r_valid && !read_ack;
  assign w_frame_set   = w_stop_tick && (w_rx != c_LINE_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_sample_cnt  <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      // Output buffer and handshake.
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (read_ack) begin
        r_valid <= 1'b0;
      end

      // Sticky error flags: a new error wins over a simultaneous clear.
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end

      if (w_overrun_set) begin
        r_overrun_err <= 1'b1;
      end else if (err_clr) begin
        r_overrun_err <= 1'b0;
      end

      // Frame sequencing only moves on sample ticks.
      if (sample_tick) begin
        case (r_state)
          IDLE: begin
            if (w_rx != c_LINE_IDLE) begin
              r_state      <= START;
              r_busy       <= 1'b1;
              r_sample_cnt <= '0;
            end
          end

          START: begin
            if (r_sample_cnt == c_SAMPLE_MID) begin
              // Middle of the start bit: a high line means it was a glitch.
              if (w_rx != c_LINE_IDLE) begin
                r_state      <= RECV;
                r_sample_cnt <= '0;
                r_bit_cnt    <= '0;
              end else begin
                r_state      <= IDLE;
                r_busy       <= 1'b0;
                r_sample_cnt <= '0;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + c_SAMPLE_ONE;
            end
          end

          RECV: begin
            if (r_sample_cnt == c_SAMPLE_LAST) begin
              // Bits arrive LSB first, so shifting right leaves bit 0 in
              // the LSB once all data bits are in.
              r_shift      <= {w_rx, r_shift[DATA_BITS-1:1]};
              r_bit_cnt    <= r_bit_cnt + c_BIT_ONE;
              r_sample_cnt <= '0;
              if (r_bit_cnt == c_BIT_LAST) begin
                r_state <= STOP;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + c_SAMPLE_ONE;
            end
          end

          STOP: begin
            if (r_sample_cnt == c_SAMPLE_LAST) begin
              r_state      <= IDLE;
              r_busy       <= 1'b0;
              r_sample_cnt <= '0;
            end else begin
              r_sample_cnt <= r_sample_cnt + c_SAMPLE_ONE;
            end
          end

          default: begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_sample_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign rx_busy     = r_busy;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver (OVERSAMPLE=8, one
//             sample_tick every 4 clk). A frame-level reference model tracks
//             the expected output byte, valid flag and error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  logic       clk;
  logic       rstn;
  logic       serial_in;
  logic       sample_tick;
  logic       read_ack;
  logic       err_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  uart_receiver dut (
    .clk         (clk),
    .rstn        (rstn),
    .serial_in   (serial_in),
    .sample_tick (sample_tick),
    .read_ack    (read_ack),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (frame level).
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_frame;
  logic       m_over;

  // Snapshots taken by send_frame around the stop-bit centre tick.
  logic        pre_valid;
  logic        pre_busy;
  logic [11:0] post_obs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 4 clk, changed on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  // Wait for n tick edges, then return on the following falling edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (sample_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_frame = 1'b0;
    m_over  = 1'b0;
  endtask

  // Send one frame; optionally pulse read_ack / err_clr in the clk cycle of
  // the stop-bit centre tick. Updates the reference model.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic ack, input logic clr);
    logic set_f;
    logic set_o;
    serial_in = 1'b0;
    wait_ticks(8);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_ticks(8);
    end
    serial_in = stop;
    wait_ticks(4);
    pre_valid = data_valid;
    pre_busy  = rx_busy;
    repeat (3) @(negedge clk);
    read_ack = ack;
    err_clr  = clr;
    @(negedge clk);
    read_ack  = 1'b0;
    err_clr   = 1'b0;
    serial_in = 1'b1;
    post_obs  = {data_out, data_valid, rx_busy, frame_err, overrun_err};

    set_f = !stop;
    set_o = stop && m_valid && !ack;
    if (stop && (!m_valid || ack)) begin
      m_data  = b;
      m_valid = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0;
    end
    m_frame = set_f || (m_frame && !clr);
    m_over  = set_o || (m_over && !clr);
    wait_ticks(3);
  endtask

  task automatic test_reset();
    rstn = 1'b0; serial_in = 1'b1; read_ack = 1'b0; err_clr = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_frame = 1'b0; m_over = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, data_valid, rx_busy, frame_err, overrun_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h",
               {data_out, data_valid, rx_busy, frame_err, overrun_err}, 12'h000);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pre_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency_pre: got valid=%b expected 0", pre_valid);
    end
    checks++;
    if (pre_busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_in_stop: got %b expected 1", pre_busy);
    end
    checks++;
    if (post_obs !== {8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_A5: got %h expected %h", post_obs, {8'hA5, 4'b1000});
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after: got busy=%b expected 0", rx_busy);
    end
  endtask

  task automatic test_glitch();
    do_ack();
    serial_in = 1'b0;
    wait_ticks(1);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL glitch_start_entered: got busy=%b expected 1", rx_busy);
    end
    wait_ticks(1);
    serial_in = 1'b1;
    wait_ticks(6);
    checks++;
    if ({data_out, data_valid, rx_busy, frame_err, overrun_err} !==
        {m_data, m_valid, 1'b0, m_frame, m_over}) begin
      errors++;
      $display("FAIL glitch_abandon: got %h expected %h",
               {data_out, data_valid, rx_busy, frame_err, overrun_err},
               {m_data, m_valid, 1'b0, m_frame, m_over});
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (post_obs !== {8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL frame_err_set: got %h expected %h", post_obs, {8'hA5, 4'b0010});
    end
    do_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL frame_err_clear: got %b expected 0", frame_err);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    checks++;
    if (post_obs !== {8'h11, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL overrun: got %h expected %h", post_obs, {8'h11, 4'b1001});
    end
    do_ack();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL ack_clears_valid: got %b expected 0", data_valid);
    end
    do_clr();
  endtask

  task automatic test_ack_at_load();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    checks++;
    if (post_obs !== {8'h22, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ack_at_load: got %h expected %h", post_obs, {8'h22, 4'b1000});
    end
  endtask

  task automatic test_reset_mid();
    serial_in = 1'b0;
    wait_ticks(8);
    for (int i = 0; i < 4; i++) begin
      serial_in = i[0];
      wait_ticks(8);
    end
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_busy: got %b expected 1", rx_busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, rx_busy, frame_err, overrun_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h",
               {data_out, data_valid, rx_busy, frame_err, overrun_err}, 12'h000);
    end
    m_data = 8'h00; m_valid = 1'b0; m_frame = 1'b0; m_over = 1'b0;
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    checks++;
    if (post_obs !== {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_next_frame: got %h expected %h", post_obs, {8'hFF, 4'b1000});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    logic       ack;
    logic       clr;
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 4) == 0);
      send_frame(b, stop, ack, clr);
      checks++;
      if (post_obs !== {m_data, m_valid, 1'b0, m_frame, m_over}) begin
        errors++;
        $display("FAIL random_frame_%0d: got %h expected %h", n, post_obs,
                 {m_data, m_valid, 1'b0, m_frame, m_over});
      end
      checks++;
      if (pre_busy !== 1'b1) begin
        errors++; $display("FAIL random_busy_%0d: got %b expected 1", n, pre_busy);
      end
      if ($urandom_range(0, 1) == 0) do_ack();
      if ($urandom_range(0, 3) == 0) do_clr();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ack_at_load();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_receiver
`default_nettype wire
